// File: rtl/ib_sync_filter.sv
// Pad-input synchronizer and persistence deglitcher that produces a clean level and edge strobes.
// Optional rising-edge counter is enabled with `define IB_SYNC_FILTER_EDGE_COUNT_EN.
module ib_sync_filter #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   CNT_WIDTH     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 I,
  input  logic                 EN,
  input  logic                 CNT_CLR,
  output logic                 O,
  output logic                 RISE,
  output logic                 FALL,
  output logic                 STABLE,
  output logic [CNT_WIDTH-1:0] CNT
);

  localparam int            FW    = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FW-1:0] FLAST = FW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   s;
  logic [FW-1:0]          fcntQ, fcntD;
  logic                   oQ, oD;
  logic                   riseQ, riseD;
  logic                   fallQ, fallD;

  // The chain samples every cycle, independent of EN, so re-enabling sees current pad state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      syncQ <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], I};
    end
  end

  assign s = syncQ[SYNC_STAGES-1];

  always_comb begin
    fcntD = fcntQ;
    oD    = oQ;
    riseD = 1'b0;
    fallD = 1'b0;
    if (EN) begin
      if (s == oQ) begin
        fcntD = '0;
      end else if (fcntQ == FLAST) begin
        oD    = s;
        fcntD = '0;
        riseD = s;
        fallD = ~s;
      end else begin
        fcntD = fcntQ + FW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fcntQ <= '0;
      oQ    <= RESET_LEVEL;
      riseQ <= 1'b0;
      fallQ <= 1'b0;
    end else begin
      fcntQ <= fcntD;
      oQ    <= oD;
      riseQ <= riseD;
      fallQ <= fallD;
    end
  end

  assign O      = oQ;
  assign RISE   = riseQ;
  assign FALL   = fallQ;
  assign STABLE = (s == oQ) && (fcntQ == '0);

`ifdef IB_SYNC_FILTER_EDGE_COUNT_EN
  logic [CNT_WIDTH-1:0] cntQ;

  // A clear coinciding with a strobe keeps that strobe as the first new count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cntQ <= '0;
    end else if (CNT_CLR) begin
      cntQ <= riseQ ? CNT_WIDTH'(1) : '0;
    end else if (riseQ && (cntQ != '1)) begin
      cntQ <= cntQ + CNT_WIDTH'(1);
    end
  end

  assign CNT = cntQ;
`else
  logic unusedCntClr;

  assign unusedCntClr = CNT_CLR;
  assign CNT          = '0;
`endif

endmodule

// File: tb/tb_ib_sync_filter.sv
// Self-checking bench for ib_sync_filter: three configurations checked against a sample-window model.
// Edge-counter checks are built when IB_SYNC_FILTER_EDGE_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_ib_sync_filter;

`ifdef IB_SYNC_FILTER_EDGE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam int SA = 2, FA = 4, CWA = 8;
  localparam int SB = 3, FB = 1, CWB = 8;
  localparam int SC = 2, FC = 2, CWC = 2;
  localparam logic RLA = 1'b0, RLB = 1'b1, RLC = 1'b0;

  localparam int SS[3]  = '{SA, SB, SC};
  localparam int FF[3]  = '{FA, FB, FC};
  localparam int CW[3]  = '{CWA, CWB, CWC};
  localparam bit RLV[3] = '{RLA, RLB, RLC};

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic I = 1'b1;
  logic EN = 1'b1;
  logic CNT_CLR = 1'b0;

  logic oW[3], riseW[3], fallW[3], stableW[3];
  logic [CWA-1:0] cntA;
  logic [CWB-1:0] cntB;
  logic [CWC-1:0] cntC;
  int cntI[3];

  int assertCount = 0;
  int failCount = 0;

  always #5 CLK = ~CLK;

  ib_sync_filter #(.SYNC_STAGES(SA), .FILTER_CYCLES(FA), .RESET_LEVEL(RLA), .CNT_WIDTH(CWA)) dutA (
    .CLK(CLK), .RST(RST), .I(I), .EN(EN), .CNT_CLR(CNT_CLR),
    .O(oW[0]), .RISE(riseW[0]), .FALL(fallW[0]), .STABLE(stableW[0]), .CNT(cntA));

  ib_sync_filter #(.SYNC_STAGES(SB), .FILTER_CYCLES(FB), .RESET_LEVEL(RLB), .CNT_WIDTH(CWB)) dutB (
    .CLK(CLK), .RST(RST), .I(I), .EN(EN), .CNT_CLR(CNT_CLR),
    .O(oW[1]), .RISE(riseW[1]), .FALL(fallW[1]), .STABLE(stableW[1]), .CNT(cntB));

  ib_sync_filter #(.SYNC_STAGES(SC), .FILTER_CYCLES(FC), .RESET_LEVEL(RLC), .CNT_WIDTH(CWC)) dutC (
    .CLK(CLK), .RST(RST), .I(I), .EN(EN), .CNT_CLR(CNT_CLR),
    .O(oW[2]), .RISE(riseW[2]), .FALL(fallW[2]), .STABLE(stableW[2]), .CNT(cntC));

  assign cntI[0] = 32'(cntA);
  assign cntI[1] = 32'(cntB);
  assign cntI[2] = 32'(cntC);

  // Model: pad samples delayed by the chain length, plus the last FILTER_CYCLES enabled samples.
  // The level flips once every sample in a full window disagrees with the current level.
  bit mPipe[3][4];
  bit mWin[3][8];
  int mWinLen[3];
  bit mO[3], mRise[3], mFall[3];
  int mCnt[3];

  task automatic modelStep(input int k);
    bit s, prevRise, allDiff;
    s = mPipe[k][SS[k]-1];
    prevRise = mRise[k];
    if (CNT_ON) begin
      if (CNT_CLR) mCnt[k] = prevRise ? 1 : 0;
      else if (prevRise && mCnt[k] < (1 << CW[k]) - 1) mCnt[k] = mCnt[k] + 1;
    end
    mRise[k] = 1'b0;
    mFall[k] = 1'b0;
    if (EN) begin
      if (mWinLen[k] == FF[k]) begin
        for (int j = 0; j < FF[k] - 1; j++) mWin[k][j] = mWin[k][j+1];
        mWinLen[k] = mWinLen[k] - 1;
      end
      mWin[k][mWinLen[k]] = s;
      mWinLen[k] = mWinLen[k] + 1;
      if (mWinLen[k] == FF[k]) begin
        allDiff = 1'b1;
        for (int j = 0; j < FF[k]; j++) if (mWin[k][j] == mO[k]) allDiff = 1'b0;
        if (allDiff) begin
          mO[k] = s;
          mRise[k] = s;
          mFall[k] = ~s;
          mWinLen[k] = 0;
        end
      end
    end
    for (int j = 3; j > 0; j--) mPipe[k][j] = mPipe[k][j-1];
    mPipe[k][0] = I;
  endtask

  function automatic bit mStable(input int k);
    bit s, pending;
    s = mPipe[k][SS[k]-1];
    pending = (mWinLen[k] > 0) && (mWin[k][mWinLen[k]-1] != mO[k]);
    return (s == mO[k]) && !pending;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 4; j++) mPipe[k][j] = RLV[k];
        mWinLen[k] = 0;
        mO[k] = RLV[k];
        mRise[k] = 1'b0;
        mFall[k] = 1'b0;
        mCnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) modelStep(k);
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int riseAt, riseCnt, strobesB;
    RST = 1'b1; I = 1'b1; EN = 1'b1; CNT_CLR = 1'b0;
    repeat (3) tick();
    assertCount++; if (oW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL resetO: got %b expected 0", oW[0]); end
    assertCount++; if (riseW[0] !== 1'b0 || fallW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL resetStrobe: got %b%b expected 00", riseW[0], fallW[0]); end
    assertCount++; if (stableW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL resetStable: got %b expected 1", stableW[0]); end
    assertCount++; if (cntI[0] !== 0) begin failCount++; $display("[TB] FAIL resetCnt: got %0d expected 0", cntI[0]); end
    assertCount++; if (oW[1] !== 1'b1 || stableW[1] !== 1'b1) begin failCount++; $display("[TB] FAIL resetLevelB: got O=%b STABLE=%b expected 1 1", oW[1], stableW[1]); end
    RST = 1'b0;
    riseAt = 0; riseCnt = 0; strobesB = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        assertCount++; if (stableW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL stableCapture: got %b expected 1", stableW[0]); end
      end
      if (i == 2) begin
        assertCount++; if (stableW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL stableDrop: got %b expected 0", stableW[0]); end
      end
      if (riseW[0] === 1'b1) begin riseCnt++; if (riseAt == 0) riseAt = i; end
      if (riseW[1] === 1'b1 || fallW[1] === 1'b1) strobesB++;
    end
    assertCount++; if (riseAt != 1 + SA + FA - 1) begin failCount++; $display("[TB] FAIL firstRiseLatency: got %0d expected %0d", riseAt, 1 + SA + FA - 1); end
    assertCount++; if (riseCnt != 1) begin failCount++; $display("[TB] FAIL firstRiseCount: got %0d expected 1", riseCnt); end
    assertCount++; if (oW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL firstRiseO: got %b expected 1", oW[0]); end
    assertCount++; if (strobesB != 0) begin failCount++; $display("[TB] FAIL noStrobeB: got %0d expected 0", strobesB); end
  endtask

  task automatic test_glitch();
    int rises;
    bit oBad;
    EN = 1'b1; I = 1'b0;
    repeat (10) tick();
    rises = 0; oBad = 1'b0;
    for (int i = 0; i < 13; i++) begin
      I = (i < 3) ? 1'b1 : 1'b0;
      tick();
      if (riseW[0] === 1'b1) rises++;
      if (oW[0] !== 1'b0) oBad = 1'b1;
    end
    assertCount++; if (rises != 0) begin failCount++; $display("[TB] FAIL glitchRise: got %0d expected 0", rises); end
    assertCount++; if (oBad) begin failCount++; $display("[TB] FAIL glitchO: got 1 expected 0"); end
    assertCount++; if (stableW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL glitchStable: got %b expected 1", stableW[0]); end
  endtask

  task automatic test_en_freeze();
    int rises;
    bit oBad;
    EN = 1'b1; I = 1'b0;
    repeat (8) tick();
    I = 1'b1;
    repeat (4) tick();
    EN = 1'b0;
    rises = 0; oBad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (riseW[0] === 1'b1) rises++;
      if (oW[0] !== 1'b0) oBad = 1'b1;
    end
    assertCount++; if (oBad || rises != 0) begin failCount++; $display("[TB] FAIL freezeHold: got O-moved=%0d rises=%0d expected 0 0", oBad, rises); end
    assertCount++; if (stableW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL freezeStable: got %b expected 0", stableW[0]); end
    EN = 1'b1;
    tick();
    assertCount++; if (oW[0] !== 1'b0 || riseW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL freezeEarly: got O=%b RISE=%b expected 0 0", oW[0], riseW[0]); end
    tick();
    assertCount++; if (oW[0] !== 1'b1 || riseW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL freezeRise: got O=%b RISE=%b expected 1 1", oW[0], riseW[0]); end
    tick();
    assertCount++; if (riseW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL freezeRiseWidth: got %b expected 0", riseW[0]); end
  endtask

  task automatic test_fall_f1();
    int fallAt, falls;
    EN = 1'b1; I = 1'b1;
    repeat (8) tick();
    assertCount++; if (oW[1] !== 1'b1) begin failCount++; $display("[TB] FAIL fallSetup: got %b expected 1", oW[1]); end
    I = 1'b0;
    fallAt = 0; falls = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (fallW[1] === 1'b1) begin falls++; if (fallAt == 0) fallAt = i; end
    end
    assertCount++; if (fallAt != 1 + SB) begin failCount++; $display("[TB] FAIL fallLatency: got %0d expected %0d", fallAt, 1 + SB); end
    assertCount++; if (falls != 1 || oW[1] !== 1'b0) begin failCount++; $display("[TB] FAIL fallPulse: got count=%0d O=%b expected 1 0", falls, oW[1]); end
  endtask

  task automatic test_reset_midfilter();
    int riseAt, rises;
    EN = 1'b1; I = 1'b0;
    repeat (8) tick();
    I = 1'b1;
    repeat (5) tick();
    assertCount++; if (oW[0] !== 1'b0 || stableW[0] !== 1'b0) begin failCount++; $display("[TB] FAIL midSetup: got O=%b STABLE=%b expected 0 0", oW[0], stableW[0]); end
    RST = 1'b1;
    tick();
    assertCount++; if (oW[0] !== 1'b0 || riseW[0] !== 1'b0 || stableW[0] !== 1'b1) begin failCount++; $display("[TB] FAIL midReset: got O=%b RISE=%b STABLE=%b expected 0 0 1", oW[0], riseW[0], stableW[0]); end
    RST = 1'b0;
    riseAt = 0; rises = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (riseW[0] === 1'b1) begin rises++; if (riseAt == 0) riseAt = i; end
    end
    assertCount++; if (riseAt != 1 + SA + FA - 1 || rises != 1) begin failCount++; $display("[TB] FAIL midRestart: got at=%0d count=%0d expected %0d 1", riseAt, rises, 1 + SA + FA - 1); end
  endtask

  task automatic test_random();
    int runLeft;
    runLeft = 0;
    for (int c = 0; c < 800; c++) begin
      if (runLeft == 0) begin
        I = 1'($urandom_range(0, 1));
        runLeft = $urandom_range(1, 7);
      end
      runLeft--;
      EN = ($urandom_range(0, 9) != 0);
      CNT_CLR = ($urandom_range(0, 15) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        assertCount++; if (oW[k] !== mO[k]) begin failCount++; $display("[TB] FAIL rndO[%0d] cyc %0d: got %b expected %b", k, c, oW[k], mO[k]); end
        assertCount++; if (riseW[k] !== mRise[k]) begin failCount++; $display("[TB] FAIL rndRise[%0d] cyc %0d: got %b expected %b", k, c, riseW[k], mRise[k]); end
        assertCount++; if (fallW[k] !== mFall[k]) begin failCount++; $display("[TB] FAIL rndFall[%0d] cyc %0d: got %b expected %b", k, c, fallW[k], mFall[k]); end
        assertCount++; if (stableW[k] !== mStable(k)) begin failCount++; $display("[TB] FAIL rndStable[%0d] cyc %0d: got %b expected %b", k, c, stableW[k], mStable(k)); end
        assertCount++; if (cntI[k] !== mCnt[k]) begin failCount++; $display("[TB] FAIL rndCnt[%0d] cyc %0d: got %0d expected %0d", k, c, cntI[k], mCnt[k]); end
      end
    end
    EN = 1'b1;
    CNT_CLR = 1'b0;
  endtask

`ifdef IB_SYNC_FILTER_EDGE_COUNT_EN
  task automatic test_edge_count();
    int expCnt[4];
    bit seen;
    expCnt = '{1, 2, 3, 3};
    EN = 1'b1; I = 1'b0; CNT_CLR = 1'b0;
    repeat (6) tick();
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    assertCount++; if (cntI[2] !== 0) begin failCount++; $display("[TB] FAIL cntClear: got %0d expected 0", cntI[2]); end
    for (int n = 0; n < 4; n++) begin
      I = 1'b1;
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        tick();
        if (riseW[2] === 1'b1) seen = 1'b1;
      end
      tick();
      assertCount++; if (!seen || cntI[2] !== expCnt[n]) begin failCount++; $display("[TB] FAIL cntEdge%0d: got %0d (rise seen %0d) expected %0d", n + 1, cntI[2], seen, expCnt[n]); end
      I = 1'b0;
      repeat (6) tick();
    end
    I = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      tick();
      if (riseW[2] === 1'b1) seen = 1'b1;
    end
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    assertCount++; if (!seen || cntI[2] !== 1) begin failCount++; $display("[TB] FAIL cntClrWithRise: got %0d (rise seen %0d) expected 1", cntI[2], seen); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_glitch();
    test_en_freeze();
    test_fall_f1();
    test_reset_midfilter();
    test_random();
`ifdef IB_SYNC_FILTER_EDGE_COUNT_EN
    test_edge_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
